// File: rtl/imem_responder.sv
// Instruction-memory responder: one outstanding fetch at a time, fixed LATENCY, response held until accepted.
// Optional build macro IMEM_STATS_EN adds a FetchCount port that counts completed response handshakes.
module imem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                     CLK,
  input  logic                     ResetN,
  input  logic                     ReqValid,
  output logic                     ReqReady,
  input  logic [31:0]              ReqAddr,
  output logic                     RespValid,
  input  logic                     RespReady,
  output logic [31:0]              RespInstr,
  output logic [31:0]              RespAddr,
  output logic                     RespErr,
  input  logic                     Flush,
  input  logic                     LoadEn,
  input  logic [$clog2(DEPTH)-1:0] LoadAddr,
  input  logic [31:0]              LoadData
`ifdef IMEM_STATS_EN
  ,
  output logic [31:0]              FetchCount
`endif
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH];
  logic        req_err;
  logic [AW-1:0] req_idx;

  // NOTE: the instruction array has no reset; its contents come only from the load port.
  always_ff @(posedge CLK) begin
    if (LoadEn) mem[LoadAddr] <= LoadData;
  end

  assign req_idx  = ReqAddr[AW+1:2];
  assign req_err  = (ReqAddr[1:0] != 2'b00) || ((ReqAddr >> 2) >= 32'(DEPTH));
  assign ReqReady = (state == S_IDLE);

  // The array read in IDLE sees the pre-edge word, so a same-edge load to that word is not forwarded.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      state     <= S_IDLE;
      cnt       <= '0;
      RespValid <= 1'b0;
      RespInstr <= '0;
      RespAddr  <= '0;
      RespErr   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ReqValid && !Flush) begin
            state     <= S_WAIT;
            cnt       <= LAT_M1;
            RespAddr  <= ReqAddr;
            RespErr   <= req_err;
            RespInstr <= req_err ? NOP : mem[req_idx];
          end
        end
        S_WAIT: begin
          if (Flush) begin
            state <= S_IDLE;
          end else if (cnt == '0) begin
            state     <= S_RESP;
            RespValid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (Flush || RespReady) begin
            state     <= S_IDLE;
            RespValid <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          RespValid <= 1'b0;
        end
      endcase
    end
  end

`ifdef IMEM_STATS_EN
  // A flush coinciding with RespReady still completes the handshake and is counted.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      FetchCount <= '0;
    end else if (RespValid && RespReady) begin
      FetchCount <= FetchCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: transaction-level model compared every cycle plus directed literal checks.
// Honours IMEM_STATS_EN when the design is built with it.
module tb_imem_responder;

  localparam int          DEPTH   = 256;
  localparam int          LATENCY = 2;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        CLK;
  logic        ResetN;
  logic        ReqValid;
  logic        ReqReady;
  logic [31:0] ReqAddr;
  logic        RespValid;
  logic        RespReady;
  logic [31:0] RespInstr;
  logic [31:0] RespAddr;
  logic        RespErr;
  logic        Flush;
  logic        LoadEn;
  logic [7:0]  LoadAddr;
  logic [31:0] LoadData;
`ifdef IMEM_STATS_EN
  logic [31:0] FetchCount;
`endif

  imem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .CLK       (CLK),
    .ResetN    (ResetN),
    .ReqValid  (ReqValid),
    .ReqReady  (ReqReady),
    .ReqAddr   (ReqAddr),
    .RespValid (RespValid),
    .RespReady (RespReady),
    .RespInstr (RespInstr),
    .RespAddr  (RespAddr),
    .RespErr   (RespErr),
    .Flush     (Flush),
    .LoadEn    (LoadEn),
    .LoadAddr  (LoadAddr),
    .LoadData  (LoadData)
`ifdef IMEM_STATS_EN
    ,
    .FetchCount(FetchCount)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a request is "busy" from acceptance until handshake or flush,
  // and its response is visible once LATENCY edges have passed since acceptance.
  logic [31:0] m_mem [DEPTH];
  bit          m_busy;
  int          m_age;
  logic [31:0] m_addr, m_instr;
  logic        m_err;
  logic [31:0] m_count;
  bit          m_v;

  always @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      m_busy  = 0;
      m_age   = 0;
      m_addr  = 0;
      m_instr = 0;
      m_err   = 0;
      m_count = 0;
    end else begin
      m_v = m_busy && (m_age >= LATENCY);
      if (m_busy) begin
        if (m_v && RespReady) m_count = m_count + 1;
        if (Flush || (m_v && RespReady)) m_busy = 0;
        else m_age++;
      end else if (ReqValid && !Flush) begin
        m_busy  = 1;
        m_age   = 0;
        m_addr  = ReqAddr;
        m_err   = (ReqAddr % 4 != 0) || ((ReqAddr / 4) >= DEPTH);
        m_instr = m_err ? NOP : m_mem[int'(ReqAddr / 4)];
      end
      if (LoadEn) m_mem[LoadAddr] = LoadData;
    end
  end

  always @(negedge CLK) begin
    if (check_en && ResetN) begin
      check("model_req_ready", 32'(ReqReady), 32'(!m_busy));
      check("model_resp_valid", 32'(RespValid), 32'(m_busy && (m_age >= LATENCY)));
      check("model_resp_instr", RespInstr, m_instr);
      check("model_resp_addr", RespAddr, m_addr);
      check("model_resp_err", 32'(RespErr), 32'(m_err));
`ifdef IMEM_STATS_EN
      check("model_fetch_count", FetchCount, m_count);
`endif
    end
  end

  task automatic load_word(input logic [7:0] idx, input logic [31:0] data);
    @(negedge CLK);
    LoadEn = 1; LoadAddr = idx; LoadData = data;
    @(negedge CLK);
    LoadEn = 0;
  endtask

  task automatic issue(input logic [31:0] addr, input logic rr);
    @(negedge CLK);
    ReqValid = 1; ReqAddr = addr; RespReady = rr;
    @(negedge CLK);
    ReqValid = 0;
  endtask

  task automatic wait_valid(input string name);
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (RespValid === 1'b1) begin
        seen = 1;
        break;
      end
      @(negedge CLK);
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: RespValid timeout, got 0 expected 1", name);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ResetN = 0; ReqValid = 0; ReqAddr = 0; RespReady = 0; Flush = 0;
    LoadEn = 0; LoadAddr = 0; LoadData = 0;
    #12;
    check("rst_resp_valid", 32'(RespValid), 32'h0);
    check("rst_resp_instr", RespInstr, 32'h0);
    check("rst_resp_addr", RespAddr, 32'h0);
    check("rst_resp_err", 32'(RespErr), 32'h0);
    check("rst_req_ready", 32'(ReqReady), 32'h1);
`ifdef IMEM_STATS_EN
    check("rst_fetch_count", FetchCount, 32'h0);
`endif
    @(negedge CLK);
    ResetN = 1;
    check_en = 1;

    load_word(8'd4, 32'h0050_0093);
    load_word(8'd0, 32'h0000_0033);
    load_word(8'd64, 32'hDEAD_BEEF);

    // Basic fetch: acceptance edge, then exactly two edges to RespValid.
    issue(32'h10, 1'b1);
    check("basic_ready_low", 32'(ReqReady), 32'h0);
    check("basic_wait_valid0", 32'(RespValid), 32'h0);
    @(negedge CLK);
    check("basic_wait_valid1", 32'(RespValid), 32'h0);
    @(negedge CLK);
    check("basic_valid", 32'(RespValid), 32'h1);
    check("basic_instr", RespInstr, 32'h0050_0093);
    check("basic_addr", RespAddr, 32'h10);
    check("basic_err", 32'(RespErr), 32'h0);
    @(negedge CLK);
    check("basic_done_valid", 32'(RespValid), 32'h0);
    check("basic_done_ready", 32'(ReqReady), 32'h1);
    check("basic_hold_instr", RespInstr, 32'h0050_0093);

    // Backpressure: response held while RespReady is low.
    issue(32'h0, 1'b0);
    wait_valid("bp_wait");
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("bp_valid", 32'(RespValid), 32'h1);
      check("bp_instr", RespInstr, 32'h0000_0033);
      check("bp_addr", RespAddr, 32'h0);
      check("bp_ready", 32'(ReqReady), 32'h0);
    end
    RespReady = 1;
    @(negedge CLK);
    check("bp_release_valid", 32'(RespValid), 32'h0);
    check("bp_release_ready", 32'(ReqReady), 32'h1);

    // Misaligned and out-of-range fetches return NOP with error, same latency.
    issue(32'h102, 1'b1);
    @(negedge CLK);
    check("mis_not_early", 32'(RespValid), 32'h0);
    @(negedge CLK);
    check("mis_valid", 32'(RespValid), 32'h1);
    check("mis_err", 32'(RespErr), 32'h1);
    check("mis_instr", RespInstr, NOP);
    issue(32'h400, 1'b1);
    @(negedge CLK);
    check("oor_not_early", 32'(RespValid), 32'h0);
    @(negedge CLK);
    check("oor_valid", 32'(RespValid), 32'h1);
    check("oor_err", 32'(RespErr), 32'h1);
    check("oor_instr", RespInstr, NOP);
    check("oor_addr", RespAddr, 32'h400);
    @(negedge CLK);

    // Flush one cycle into WAIT discards the request.
    issue(32'h10, 1'b1);
    Flush = 1;
    @(negedge CLK);
    Flush = 0;
    check("flush_ready", 32'(ReqReady), 32'h1);
    check("flush_valid", 32'(RespValid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("flush_never_valid", 32'(RespValid), 32'h0);
    end

    // Flush in IDLE blocks acceptance.
    ReqValid = 1; ReqAddr = 32'h10; Flush = 1;
    @(negedge CLK);
    ReqValid = 0; Flush = 0;
    check("flush_idle_ready", 32'(ReqReady), 32'h1);

    issue(32'h0, 1'b1);
    wait_valid("flush_follow_wait");
    check("flush_follow_instr", RespInstr, 32'h0000_0033);
    @(negedge CLK);

    // Flush together with RespReady in RESP returns to IDLE.
    issue(32'h0, 1'b0);
    wait_valid("flush_rr_wait");
    Flush = 1; RespReady = 1;
    @(negedge CLK);
    Flush = 0;
    check("flush_rr_valid", 32'(RespValid), 32'h0);
    check("flush_rr_ready", 32'(ReqReady), 32'h1);

    // Same-edge load to the requested word: response carries the old word.
    @(negedge CLK);
    ReqValid = 1; ReqAddr = 32'h10; RespReady = 1;
    LoadEn = 1; LoadAddr = 8'd4; LoadData = 32'h00A0_0113;
    @(negedge CLK);
    ReqValid = 0; LoadEn = 0;
    wait_valid("rbw_wait");
    check("rbw_instr", RespInstr, 32'h0050_0093);
    @(negedge CLK);

    // Async reset mid-RESP clears outputs before the next edge.
    issue(32'h10, 1'b0);
    wait_valid("arst_wait");
    @(posedge CLK);
    #3;
    ResetN = 0;
    #1;
    check("arst_valid", 32'(RespValid), 32'h0);
    check("arst_instr", RespInstr, 32'h0);
    check("arst_addr", RespAddr, 32'h0);
    check("arst_err", 32'(RespErr), 32'h0);
    check("arst_ready", 32'(ReqReady), 32'h1);
    @(negedge CLK);
    ResetN = 1;
    issue(32'h10, 1'b1);
    wait_valid("post_rst_wait");
    check("post_rst_instr", RespInstr, 32'h00A0_0113);
    check("post_rst_addr", RespAddr, 32'h10);
    @(negedge CLK);
    check("post_rst_idle", 32'(ReqReady), 32'h1);
`ifdef IMEM_STATS_EN
    check("post_rst_count", FetchCount, 32'h1);
`endif

    repeat (2) @(negedge CLK);
    check_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
